alu_seq_unit: RTL and testbench

- Sequential, handshaked responder that executes the ALU arithmetic opcode set (ADD/SUB/MUL/DIV) and returns Result plus Flags {V,C,N,Z}.
- Requests arrive from an upstream issuer; responses go to a downstream consumer. Both sides use valid/ready.
- MUL and DIV are iterative (one bit per cycle), so any host can drive the block without a wide combinational multiplier or divider.

---
 rtl/alu_seq_unit_if.sv | 31 +++
 rtl/alu_seq_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: request/response bundle for alu_seq_unit.
//   Request side (issuer -> unit):  in_valid, A, B, Opcode, Cin; unit returns in_ready.
//   Response side (unit -> consumer): out_valid, Result, Remainder, Flags {V,C,N,Z}, op_err;
//   consumer returns out_ready.
//   master: issuer/consumer view (testbench or host). slave: the ALU unit.
interface alu_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       Opcode;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Remainder;
    logic [3:0]       Flags;
    logic             op_err;

    modport master (
        output in_valid, A, B, Opcode, Cin, out_ready,
        input  in_ready, out_valid, Result, Remainder, Flags, op_err
    );

    modport slave (
        input  in_valid, A, B, Opcode, Cin, out_ready,
        output in_ready, out_valid, Result, Remainder, Flags, op_err
    );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked sequential ALU executing ADD/SUB/MUL/DIV, one request in flight.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_seq_unit_if.slave -- valid/ready request (A, B, Opcode, Cin) and
//          valid/ready response (Result, Remainder, Flags {V,C,N,Z}, op_err)
// MUL is shift-add and DIV is restoring division, both one bit per cycle.
// Optional feature: define ALU_SEQ_EARLY_TERM_EN to let MUL finish as soon as the remaining
// multiplier bits are all zero (result and flags are unchanged, DIV latency unaffected).
module alu_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic           clk,
    input logic           rst,
    alu_seq_unit_if.slave bus
);
    localparam logic [4:0]       OpAdd   = 5'b00000;
    localparam logic [4:0]       OpSub   = 5'b00001;
    localparam logic [4:0]       OpMul   = 5'b00010;
    localparam logic [4:0]       OpDiv   = 5'b00011;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [4:0]           op_q, op_d;
    logic                 cin_q, cin_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d, remainder_q, remainder_d;
    logic [3:0]           flags_q, flags_d;
    logic                 op_err_q, op_err_d;

    // Add/subtract datapath (SUB is A + ~B + 1, so carry-out means "no borrow").
    logic [WIDTH:0] add_sum, sub_sum;
    logic           add_v, sub_v;
    assign add_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
    assign sub_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_sum[WIDTH-1] != a_q[WIDTH-1]);

    // Shift-add multiply: multiplicand shifts left, multiplier shifts right.
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_nxt;
    logic               mul_last;
    assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_nxt = mplier_q >> 1;
`ifdef ALU_SEQ_EARLY_TERM_EN
    // No set multiplier bits left means no further partial products to add.
    assign mul_last = (mplier_nxt == '0) || (cnt_q == LastCnt);
`else
    assign mul_last = (cnt_q == LastCnt);
`endif

    // Restoring divide: partial remainder is always < B, so the trial fits WIDTH+1 bits and
    // the top bit of the difference is the borrow.
    logic [WIDTH:0]   div_trial, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_step, quo_step;
    assign div_trial = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, b_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign rem_step  = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], div_ge};

    // Completion bundle from EXEC; committed to the output registers in one place.
    logic             fin, fin_v, fin_c, fin_err;
    logic [WIDTH-1:0] fin_res, fin_rem;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cin_d       = cin_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        flags_d     = flags_q;
        op_err_d    = op_err_q;
        fin         = 1'b0;
        fin_v       = 1'b0;
        fin_c       = 1'b0;
        fin_err     = 1'b0;
        fin_res     = '0;
        fin_rem     = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    op_d     = bus.Opcode;
                    cin_d    = bus.Cin;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    rem_d    = '0;
                    quo_d    = bus.A;
                    state_d  = StExec;
                end
            end
            StExec: begin
                cnt_d = cnt_q + CNT_W'(1);
                case (op_q)
                    OpAdd: begin
                        fin     = 1'b1;
                        fin_res = add_sum[WIDTH-1:0];
                        fin_c   = add_sum[WIDTH];
                        fin_v   = add_v;
                    end
                    OpSub: begin
                        fin     = 1'b1;
                        fin_res = sub_sum[WIDTH-1:0];
                        fin_c   = sub_sum[WIDTH];
                        fin_v   = sub_v;
                    end
                    OpMul: begin
                        acc_d    = acc_step;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_nxt;
                        if (mul_last) begin
                            fin     = 1'b1;
                            fin_res = acc_step[WIDTH-1:0];
                            fin_c   = |acc_step[2*WIDTH-1:WIDTH];
                            fin_v   = |acc_step[2*WIDTH-1:WIDTH];
                        end
                    end
                    OpDiv: begin
                        if (b_q == '0) begin
                            fin     = 1'b1;
                            fin_res = '1;
                            fin_rem = a_q;
                            fin_v   = 1'b1;
                        end else begin
                            rem_d = rem_step;
                            quo_d = quo_step;
                            if (cnt_q == LastCnt) begin
                                fin     = 1'b1;
                                fin_res = quo_step;
                                fin_rem = rem_step;
                            end
                        end
                    end
                    default: begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                endcase
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fin) begin
            state_d     = StDone;
            result_d    = fin_res;
            remainder_d = fin_rem;
            flags_d     = {fin_v, fin_c, fin_res[WIDTH-1], fin_res == '0};
            op_err_d    = fin_err;
        end

        // Registered handshakes: in_ready stays low through the first edge after reset.
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cin_q       <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            flags_q     <= '0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cin_q       <= cin_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            flags_q     <= flags_d;
            op_err_q    <= op_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Remainder = remainder_q;
    assign bus.Flags     = flags_q;
    assign bus.op_err    = op_err_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: table-driven bench for alu_seq_unit with an expected-response queue,
// plus hand-written sequences for backpressure and mid-operation reset.
`timescale 1ns/1ps
module tb_alu_seq_unit;
    localparam int unsigned W = 32;
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_BAD = 5'b11111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic        cin;
        logic [31:0] res;
        logic [31:0] rem;
        logic [3:0]  flags;
        logic        err;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t exp_q[$];
    vec_t vecs[14];

    alu_seq_unit_if #(.WIDTH(W)) bus ();

    alu_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mul_lat(input logic [31:0] b);
`ifdef ALU_SEQ_EARLY_TERM_EN
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    // Reference model using plain wide arithmetic.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] op, input logic cin);
        vec_t        v;
        logic [32:0] s;
        logic [63:0] p;
        logic        fv, fc;
        v = '0; v.a = a; v.b = b; v.op = op; v.cin = cin;
        fv = 1'b0; fc = 1'b0; v.lat = 1;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + 33'(cin);
                v.res = s[31:0]; fc = s[32];
                fv = (a[31] == b[31]) && (v.res[31] != a[31]);
            end
            OP_SUB: begin
                v.res = a - b; fc = (a >= b);
                fv = (a[31] != b[31]) && (v.res[31] != a[31]);
            end
            OP_MUL: begin
                p = 64'(a) * 64'(b);
                v.res = p[31:0]; fc = (p[63:32] != 0); fv = fc;
                v.lat = mul_lat(b);
            end
            OP_DIV: begin
                if (b == 0) begin
                    v.res = 32'hFFFF_FFFF; v.rem = a; fv = 1'b1;
                end else begin
                    v.res = a / b; v.rem = a % b; v.lat = 32;
                end
            end
            default: v.err = 1'b1;
        endcase
        v.flags = {fv, fc, v.res[31], v.res == 0};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_resp(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: response with no expectation", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, " Result"}, 64'(bus.Result), 64'(e.res));
        check({tag, " Remainder"}, 64'(bus.Remainder), 64'(e.rem));
        check({tag, " Flags"}, 64'(bus.Flags), 64'(e.flags));
        check({tag, " op_err"}, 64'(bus.op_err), 64'(e.err));
    endtask

    // Waits (bounded) for out_valid; returns edges counted since the accept edge.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic cin);
        bus.A = a; bus.B = b; bus.Opcode = op; bus.Cin = cin; bus.in_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'(1));
        drive(v.a, v.b, v.op, v.cin);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(v);
        check({tag, " in_ready busy"}, 64'(bus.in_ready), 64'(0));
        wait_out(lat);
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        compare_resp(tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid dropped"}, 64'(bus.out_valid), 64'(0));
        check({tag, " in_ready back"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        int   lat;
        int   stale;
        vec_t v;
        checks = 0;
        errors = 0;

        vecs[0]  = '{a: 32'd10, b: 32'd20, op: OP_ADD, cin: 0, res: 32'd30, rem: 0,
                     flags: 4'b0000, err: 0, lat: 1};
        vecs[1]  = '{a: 32'hFFFF_FFFF, b: 32'd1, op: OP_ADD, cin: 0, res: 32'd0, rem: 0,
                     flags: 4'b0101, err: 0, lat: 1};
        vecs[2]  = '{a: 32'h7FFF_FFFF, b: 32'd1, op: OP_ADD, cin: 0, res: 32'h8000_0000, rem: 0,
                     flags: 4'b1010, err: 0, lat: 1};
        vecs[3]  = '{a: 32'd5, b: 32'd3, op: OP_ADD, cin: 1, res: 32'd9, rem: 0,
                     flags: 4'b0000, err: 0, lat: 1};
        vecs[4]  = '{a: 32'd50, b: 32'd20, op: OP_SUB, cin: 0, res: 32'd30, rem: 0,
                     flags: 4'b0100, err: 0, lat: 1};
        vecs[5]  = '{a: 32'd20, b: 32'd50, op: OP_SUB, cin: 0, res: 32'hFFFF_FFE2, rem: 0,
                     flags: 4'b0010, err: 0, lat: 1};
        vecs[6]  = '{a: 32'h8000_0000, b: 32'd1, op: OP_SUB, cin: 0, res: 32'h7FFF_FFFF, rem: 0,
                     flags: 4'b1100, err: 0, lat: 1};
        vecs[7]  = '{a: 32'd5, b: 32'd5, op: OP_SUB, cin: 1, res: 32'd0, rem: 0,
                     flags: 4'b0101, err: 0, lat: 1};
        vecs[8]  = '{a: 32'd6, b: 32'd7, op: OP_MUL, cin: 0, res: 32'd42, rem: 0,
                     flags: 4'b0000, err: 0, lat: mul_lat(32'd7)};
        vecs[9]  = '{a: 32'hFFFF_FFFF, b: 32'd2, op: OP_MUL, cin: 0, res: 32'hFFFF_FFFE, rem: 0,
                     flags: 4'b1110, err: 0, lat: mul_lat(32'd2)};
        vecs[10] = '{a: 32'd100, b: 32'd5, op: OP_DIV, cin: 0, res: 32'd20, rem: 0,
                     flags: 4'b0000, err: 0, lat: 32};
        vecs[11] = '{a: 32'd100, b: 32'd0, op: OP_DIV, cin: 0, res: 32'hFFFF_FFFF, rem: 32'd100,
                     flags: 4'b1010, err: 0, lat: 1};
        vecs[12] = '{a: 32'd7, b: 32'd9, op: OP_DIV, cin: 0, res: 32'd0, rem: 32'd7,
                     flags: 4'b0001, err: 0, lat: 32};
        vecs[13] = '{a: 32'd12, b: 32'd34, op: OP_BAD, cin: 1, res: 32'd0, rem: 0,
                     flags: 4'b0001, err: 1, lat: 1};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Opcode = '0; bus.Cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(bus.in_ready), 64'(0));
        check("reset out_valid", 64'(bus.out_valid), 64'(0));
        check("reset Result", 64'(bus.Result), 64'(0));
        check("reset Remainder", 64'(bus.Remainder), 64'(0));
        check("reset Flags", 64'(bus.Flags), 64'(0));
        check("reset op_err", 64'(bus.op_err), 64'(0));
        rst = 1'b0;
        #1;
        check("in_ready before first edge", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        check("in_ready after first edge", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            v = model($urandom, (i == 5) ? 32'd0 : $urandom, 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            run_vec(v, $sformatf("rand%0d", i));
        end

        // Backpressure: response held while a second request waits.
        drive(32'd1000, 32'd234, OP_ADD, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(32'd1000, 32'd234, OP_ADD, 1'b0));
        wait_out(lat);
        compare_resp("bp first");
        drive(32'd1, 32'd2, OP_ADD, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d out_valid", k), 64'(bus.out_valid), 64'(1));
            check($sformatf("bp hold%0d in_ready", k), 64'(bus.in_ready), 64'(0));
            check($sformatf("bp hold%0d Result", k), 64'(bus.Result), 64'(1234));
            check($sformatf("bp hold%0d Flags", k), 64'(bus.Flags), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp release out_valid", 64'(bus.out_valid), 64'(0));
        check("bp release in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(32'd1, 32'd2, OP_ADD, 1'b0));
        check("bp second accepted", 64'(bus.in_ready), 64'(0));
        wait_out(lat);
        check("bp second latency", 64'(lat), 64'(1));
        compare_resp("bp second");
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset during DIV EXEC cycle 10 aborts with no response.
        drive(32'd1000, 32'd3, OP_DIV, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(32'd1000, 32'd3, OP_DIV, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        check("mid div out_valid", 64'(bus.out_valid), 64'(0));
        rst = 1'b1;
        #1;
        check("abort in_ready", 64'(bus.in_ready), 64'(0));
        check("abort out_valid", 64'(bus.out_valid), 64'(0));
        check("abort Result", 64'(bus.Result), 64'(0));
        check("abort Remainder", 64'(bus.Remainder), 64'(0));
        check("abort Flags", 64'(bus.Flags), 64'(0));
        check("abort op_err", 64'(bus.op_err), 64'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post abort in_ready", 64'(bus.in_ready), 64'(1));
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        check("no stale response", 64'(stale), 64'(0));
        run_vec(model(32'd1000, 32'd3, OP_DIV, 1'b0), "post abort div");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
